sc2110_frame_tx: RTL and testbench
==================================

SC2110_FRAME_TX -- requirements
Module: sc2110_frame_tx

Interface
REQ-001 Parameter DW, 12, pixel data width.
REQ-002 Parameter H_ACTIVE, 1920, active pixels per line.
REQ-003 Parameter H_BLANK, 280, blanking cycles per line (lvld low).
REQ-004 Parameter V_ACTIVE, 1080, active lines per frame.
REQ-005 Parameter V_FRONT, 4, line periods with fvld high before the first active line.
REQ-006 Parameter V_BACK, 4, line periods with fvld high after the last active line.
REQ-007 Parameter V_BLANK, 45, line periods with fvld low between frames.
REQ-008 pclk_b  in  1  pixel clock; all logic on its rising edge.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 i_en  in  1  frame generation enable.
REQ-011 i_pattern  in  1  0 = FIFO data, 1 = internal ramp.
REQ-012 i_fifo_empty  in  1  upstream FIFO empty.
REQ-013 o_fifo_rd_en  out  1  upstream FIFO read strobe; data valid on i_fifo_dout one cycle later.
REQ-014 i_fifo_dout  in  DW  upstream FIFO data.
REQ-015 o_fvld / o_lvld / o_dvld  out  1 each  frame, line and pixel valid.
REQ-016 o_data  out  DW  pixel data.
REQ-017 o_underflow  out  1  sticky: a pixel in the current frame found the FIFO empty.
REQ-018 o_frame_done  out  1  one-cycle pulse at the end of the V_BACK period.

Function
REQ-019 States: IDLE, FRONT, ACTIVE, HBLANK, BACK, VBLANK; a line period is H_ACTIVE+H_BLANK cycles.
REQ-020 IDLE -> FRONT when i_en=1; VBLANK end -> FRONT if i_en=1, else IDLE.
REQ-021 FRONT: V_FRONT line periods, fvld=1, lvld=0; then ACTIVE.
REQ-022 ACTIVE: H_ACTIVE cycles, lvld=1; then HBLANK for H_BLANK cycles; after line V_ACTIVE goes to BACK, otherwise back to ACTIVE.
REQ-023 BACK: V_BACK line periods with fvld=1, then VBLANK; VBLANK: V_BLANK line periods with fvld=0.
REQ-024 A zero-valued V_FRONT, V_BACK or V_BLANK skips that state.
REQ-025 Deasserting i_en mid-frame has no effect until the current frame completes.
REQ-026 o_fifo_rd_en = ACTIVE && !i_pattern && !i_fifo_empty, combinational from the state and count registers.
REQ-027 All outputs are registered and delayed one cycle from the internal state, so o_data aligns with the FIFO read latency.
REQ-028 o_lvld is high for exactly H_ACTIVE consecutive cycles per active line.
REQ-029 o_dvld=1 only for pixels that were actually read, or for every active pixel when i_pattern=1.
REQ-030 Underflow pixel: o_dvld=0 and o_data=0, while o_lvld stays high.
REQ-031 Ramp pattern: o_data = pixel column index (0..H_ACTIVE-1) truncated to DW bits.
REQ-032 i_pattern is sampled at FRONT entry and held for the whole frame.
REQ-033 o_underflow is set on any underflow pixel and cleared on FRONT entry.
REQ-034 When fvld=0 or lvld=0: o_dvld=0, o_data=0.
REQ-035 Pixel and line counters wrap to 0 at end of line and end of state; they never exceed their parameter minus one.

Reset
REQ-036 While rst_n=0: state=IDLE, all counters 0, o_fvld=o_lvld=o_dvld=0, o_data=0, o_underflow=0, o_frame_done=0, o_fifo_rd_en=0.
REQ-037 Reset asserted mid-frame aborts the frame immediately; after release the block waits in IDLE for i_en.

Structure
REQ-038 Package sc2110_pkg holds the state encoding constants and default timing constants; the parameters default from it.
REQ-039 One sub-module, sc2110_line_cnt, generates the pixel counter, line-period counter and end-of-line/end-of-state strobes.

Verification
Common settings: H_ACTIVE=8, H_BLANK=4, V_ACTIVE=3, V_FRONT=1, V_BACK=1, V_BLANK=2, DW=12.
REQ-040 Bench: i_en=1, i_pattern=1 -> fvld high 60 cycles, low 24 cycles (84-cycle frame); 3 lvld pulses of 8 cycles each with data 0..7; o_frame_done pulses once per frame.
REQ-041 Bench: i_pattern=0, FIFO preloaded with 24 words 0x100..0x117 -> 24 reads; o_data matches 0x100..0x117 in order with o_dvld high; o_underflow=0.
REQ-042 Bench: i_pattern=0, FIFO holding 10 words -> 10 dvld pixels, then 14 pixels with o_dvld=0, o_data=0, lvld unchanged; o_underflow=1 until next FRONT entry.
REQ-043 Bench: i_en dropped during line 2 -> frame completes (frame_done pulse), block enters IDLE after VBLANK, no further fvld.
REQ-044 Bench: rst_n pulsed low during ACTIVE -> all outputs 0 within the same cycle; next frame restarts with FRONT and column 0.
REQ-045 Bench: i_pattern toggled mid-frame -> no change until the next frame.

Source files
------------

// File: rtl/sc2110_pkg.sv
// sc2110_pkg -- shared definitions for the SC2110 frame transmitter.
//   state_t      : frame sequencer state encoding
//   DEF_*        : default timing/width constants the block parameters fall back to
//   max4()       : helper used to size the line-period counter
package sc2110_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FRONT  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLANK = 3'd3,
        ST_BACK   = 3'd4,
        ST_VBLANK = 3'd5
    } state_t;

    localparam int DEF_DW       = 12;
    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_BLANK  = 280;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FRONT  = 4;
    localparam int DEF_V_BACK   = 4;
    localparam int DEF_V_BLANK  = 45;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sc2110_line_cnt.sv
// sc2110_line_cnt -- pixel and line-period counters for the frame sequencer.
//   pclk_b, rst_n : clock, async active-low reset
//   i_run         : counters advance while high, held at 0 while low
//   i_lines       : number of line periods in the current state (>= 1)
//   o_pix         : position within the line period, 0..H_TOT-1
//   o_line        : line period within the current state, 0..i_lines-1
//   o_eol         : last cycle of a line period
//   o_eos         : last cycle of the last line period of the state
module sc2110_line_cnt #(
    parameter int H_TOT = 2200,
    parameter int PW    = 12,
    parameter int LW    = 11
) (
    input  logic          pclk_b,
    input  logic          rst_n,
    input  logic          i_run,
    input  logic [LW-1:0] i_lines,
    output logic [PW-1:0] o_pix,
    output logic [LW-1:0] o_line,
    output logic          o_eol,
    output logic          o_eos
);

    logic [PW-1:0] r_pix;
    logic [LW-1:0] r_line;

    assign o_pix  = r_pix;
    assign o_line = r_line;
    assign o_eol  = i_run && (r_pix == PW'(H_TOT - 1));
    assign o_eos  = o_eol && (r_line == i_lines - LW'(1));

    // Both counters wrap on o_eos, so every state is entered with them at 0.
    always_ff @(posedge pclk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_pix  <= '0;
            r_line <= '0;
        end else if (!i_run) begin
            r_pix  <= '0;
            r_line <= '0;
        end else if (o_eol) begin
            r_pix  <= '0;
            r_line <= o_eos ? '0 : r_line + LW'(1);
        end else begin
            r_pix  <= r_pix + PW'(1);
        end
    end

endmodule

// File: rtl/sc2110_frame_tx.sv
// sc2110_frame_tx -- parallel-video frame transmitter (fvld/lvld/dvld + data).
//   pclk_b, rst_n            : pixel clock, async active-low reset
//   i_en                     : frame generation enable, sampled at frame boundaries
//   i_pattern                : 0 = FIFO data, 1 = column ramp (latched per frame)
//   i_fifo_empty/i_fifo_dout : upstream FIFO status and data (1-cycle read latency)
//   o_fifo_rd_en             : FIFO read strobe (combinational from state)
//   o_fvld/o_lvld/o_dvld     : frame/line/pixel valid
//   o_data                   : pixel data
//   o_underflow              : sticky per-frame FIFO underflow flag
//   o_frame_done             : one-cycle pulse when the back porch ends
module sc2110_frame_tx
    import sc2110_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_BLANK  = DEF_V_BLANK
) (
    input  logic          pclk_b,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_pattern,
    input  logic          i_fifo_empty,
    output logic          o_fifo_rd_en,
    input  logic [DW-1:0] i_fifo_dout,
    output logic          o_fvld,
    output logic          o_lvld,
    output logic          o_dvld,
    output logic [DW-1:0] o_data,
    output logic          o_underflow,
    output logic          o_frame_done
);

    localparam int H_TOT = H_ACTIVE + H_BLANK;
    localparam int PW    = $clog2(H_TOT + 1);
    localparam int LW    = $clog2(max4(V_ACTIVE, V_FRONT, V_BACK, V_BLANK) + 1);

    state_t        r_state, w_nxt;
    logic [PW-1:0] w_pix;
    logic [LW-1:0] w_line;
    logic [LW-1:0] w_lines;
    logic          w_eol, w_eos, w_run;
    logic          w_start, w_done;
    logic          w_fvld, w_lvld, w_rd_en;
    state_t        w_first, w_after_blank, w_after_back, w_after_active;

    logic          r_pat;
    logic          r_fvld, r_lvld, r_dvld, r_done, r_underflow, r_src_fifo;
    logic [DW-1:0] r_data;

    assign w_run = (r_state != ST_IDLE);

    always_comb begin
        w_lines = LW'(1);
        case (r_state)
            ST_FRONT:            w_lines = LW'(V_FRONT);
            ST_ACTIVE, ST_HBLANK: w_lines = LW'(V_ACTIVE);
            ST_BACK:             w_lines = LW'(V_BACK);
            ST_VBLANK:           w_lines = LW'(V_BLANK);
            default:             w_lines = LW'(1);
        endcase
    end

    sc2110_line_cnt #(.H_TOT(H_TOT), .PW(PW), .LW(LW)) u_cnt (
        .pclk_b  (pclk_b),
        .rst_n   (rst_n),
        .i_run   (w_run),
        .i_lines (w_lines),
        .o_pix   (w_pix),
        .o_line  (w_line),
        .o_eol   (w_eol),
        .o_eos   (w_eos)
    );

    // Zero-length vertical periods are skipped by chaining the successor choice.
    assign w_first        = (V_FRONT != 0) ? ST_FRONT : ST_ACTIVE;
    assign w_after_blank  = i_en ? w_first : ST_IDLE;
    assign w_after_back   = (V_BLANK != 0) ? ST_VBLANK : w_after_blank;
    assign w_after_active = (V_BACK != 0) ? ST_BACK : w_after_back;

    always_ff @(posedge pclk_b or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt   = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_nxt   = w_first;
                    w_start = 1'b1;
                end
            end
            ST_FRONT: begin
                if (w_eos) w_nxt = ST_ACTIVE;
            end
            ST_ACTIVE, ST_HBLANK: begin
                if (w_eos) begin
                    w_nxt   = w_after_active;
                    w_done  = (V_BACK == 0);
                    w_start = (V_BACK == 0) && (V_BLANK == 0) && i_en;
                end else if (w_eol) begin
                    w_nxt = ST_ACTIVE;
                end else if (r_state == ST_ACTIVE && w_pix == PW'(H_ACTIVE - 1)) begin
                    w_nxt = ST_HBLANK;
                end
            end
            ST_BACK: begin
                if (w_eos) begin
                    w_nxt   = w_after_back;
                    w_done  = 1'b1;
                    w_start = (V_BLANK == 0) && i_en;
                end
            end
            ST_VBLANK: begin
                if (w_eos) begin
                    w_nxt   = w_after_blank;
                    w_start = i_en;
                end
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    assign w_fvld  = (r_state == ST_FRONT) || (r_state == ST_ACTIVE) ||
                     (r_state == ST_HBLANK) || (r_state == ST_BACK);
    assign w_lvld  = (r_state == ST_ACTIVE);
    // Uses the per-frame latched pattern so a mid-frame toggle cannot start reads.
    assign w_rd_en = w_lvld && !r_pat && !i_fifo_empty;

    assign o_fifo_rd_en = w_rd_en;

    always_ff @(posedge pclk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_pat       <= 1'b0;
            r_fvld      <= 1'b0;
            r_lvld      <= 1'b0;
            r_dvld      <= 1'b0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
            r_src_fifo  <= 1'b0;
            r_data      <= '0;
        end else begin
            if (w_start) r_pat <= i_pattern;
            r_fvld     <= w_fvld;
            r_lvld     <= w_lvld;
            r_done     <= w_done;
            r_dvld     <= w_lvld && (r_pat || w_rd_en);
            r_src_fifo <= w_rd_en;
            r_data     <= (w_lvld && r_pat) ? DW'(w_pix) : '0;
            if (w_start)
                r_underflow <= 1'b0;
            else if (w_lvld && !r_pat && i_fifo_empty)
                r_underflow <= 1'b1;
        end
    end

    // The FIFO's own output register supplies the pixel one cycle after the
    // read, which is the same cycle the registered valids describe it.
    assign o_data       = r_src_fifo ? i_fifo_dout : r_data;
    assign o_fvld       = r_fvld;
    assign o_lvld       = r_lvld;
    assign o_dvld       = r_dvld;
    assign o_underflow  = r_underflow;
    assign o_frame_done = r_done;

endmodule

// File: tb/tb_sc2110_frame_tx.sv
module tb_sc2110_frame_tx;

    localparam int DW  = 12;
    localparam int HA  = 8;
    localparam int HB  = 4;
    localparam int VA  = 3;
    localparam int VF  = 1;
    localparam int VB  = 1;
    localparam int VBL = 2;
    localparam int LT  = HA + HB;
    localparam int FV  = (VF + VA + VB) * LT;
    localparam int TOT = FV + VBL * LT;

    logic          pclk_b = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_en = 1'b0;
    logic          i_pattern = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          o_fifo_rd_en, o_fvld, o_lvld, o_dvld, o_underflow, o_frame_done;
    logic [DW-1:0] o_data;

    sc2110_frame_tx #(.DW(DW), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
                      .V_FRONT(VF), .V_BACK(VB), .V_BLANK(VBL)) dut (
        .pclk_b       (pclk_b),
        .rst_n        (rst_n),
        .i_en         (i_en),
        .i_pattern    (i_pattern),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd_en (o_fifo_rd_en),
        .i_fifo_dout  (fifo_dout),
        .o_fvld       (o_fvld),
        .o_lvld       (o_lvld),
        .o_dvld       (o_dvld),
        .o_data       (o_data),
        .o_underflow  (o_underflow),
        .o_frame_done (o_frame_done)
    );

    always #5 pclk_b = ~pclk_b;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Upstream FIFO: registered output, one-cycle read latency.
    logic [DW-1:0] q[$];
    logic          rd_s = 1'b0;
    always @(negedge pclk_b) rd_s <= o_fifo_rd_en;
    always @(posedge pclk_b) begin
        if (rd_s && q.size() > 0) begin
            fifo_dout <= q[0];
            q.pop_front();
        end
        fifo_empty <= (q.size() == 0);
    end

    // Reference model: position within an 84-cycle frame, -1 when idle.
    logic [DW-1:0] mq[$];
    int            m_pos = -1;
    logic          m_pat = 1'b0;
    logic          m_uf = 1'b0;
    logic          e_fvld = 1'b0, e_lvld = 1'b0, e_dvld = 1'b0, e_done = 1'b0;
    logic [DW-1:0] e_data = '0;

    function automatic bit act(input int p);
        if (p < 0) return 1'b0;
        return (p / LT >= VF) && (p / LT < VF + VA) && (p % LT < HA);
    endfunction

    always @(posedge pclk_b or negedge rst_n) begin
        if (!rst_n) begin
            m_pos  <= -1;
            m_pat  <= 1'b0;
            m_uf   <= 1'b0;
            e_fvld <= 1'b0;
            e_lvld <= 1'b0;
            e_dvld <= 1'b0;
            e_done <= 1'b0;
            e_data <= '0;
        end else begin
            e_fvld <= (m_pos >= 0) && (m_pos < FV);
            e_lvld <= act(m_pos);
            e_done <= (m_pos == FV - 1);
            if (act(m_pos) && m_pat) begin
                e_dvld <= 1'b1;
                e_data <= DW'(m_pos % LT);
            end else if (act(m_pos) && mq.size() > 0) begin
                e_dvld <= 1'b1;
                e_data <= mq[0];
                mq.pop_front();
            end else begin
                e_dvld <= 1'b0;
                e_data <= '0;
                if (act(m_pos)) m_uf <= 1'b1;
            end
            if (m_pos < 0 || m_pos == TOT - 1) begin
                if (i_en) begin
                    m_pos <= 0;
                    m_pat <= i_pattern;
                    m_uf  <= 1'b0;
                end else begin
                    m_pos <= -1;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    // Per-cycle comparison plus running event counters.
    int   c_fvld = 0, c_lvld = 0, c_dvld = 0, c_done = 0, c_rd = 0, c_lrise = 0;
    logic prev_lvld = 1'b0;
    always @(negedge pclk_b) begin
        chk("fvld",  32'(o_fvld),       32'(e_fvld));
        chk("lvld",  32'(o_lvld),       32'(e_lvld));
        chk("dvld",  32'(o_dvld),       32'(e_dvld));
        chk("data",  32'(o_data),       32'(e_data));
        chk("done",  32'(o_frame_done), 32'(e_done));
        chk("uflow", 32'(o_underflow),  32'(m_uf));
        chk("rd_en", 32'(o_fifo_rd_en), 32'(act(m_pos) && !m_pat && mq.size() > 0));
        c_fvld  += int'(o_fvld);
        c_lvld  += int'(o_lvld);
        c_dvld  += int'(o_dvld);
        c_done  += int'(o_frame_done);
        c_rd    += int'(o_fifo_rd_en);
        c_lrise += int'(o_lvld && !prev_lvld);
        prev_lvld <= o_lvld;
    end

    int s_fvld, s_lvld, s_dvld, s_done, s_rd, s_lrise;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge pclk_b);
            #1;
        end
    endtask

    task automatic snap();
        s_fvld  = c_fvld;
        s_lvld  = c_lvld;
        s_dvld  = c_dvld;
        s_done  = c_done;
        s_rd    = c_rd;
        s_lrise = c_lrise;
    endtask

    task automatic preload(input int n, input int base, input bit rnd);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? DW'($urandom) : DW'(base + i);
            q.push_back(w);
            mq.push_back(w);
        end
    endtask

    initial begin
        // reset state
        step(3);
        chk("rst_fvld",  32'(o_fvld),       0);
        chk("rst_lvld",  32'(o_lvld),       0);
        chk("rst_dvld",  32'(o_dvld),       0);
        chk("rst_data",  32'(o_data),       0);
        chk("rst_uflow", 32'(o_underflow),  0);
        chk("rst_done",  32'(o_frame_done), 0);
        chk("rst_rd",    32'(o_fifo_rd_en), 0);
        rst_n = 1'b1;
        step(2);

        // ramp pattern, two back-to-back frames
        snap();
        i_pattern = 1'b1;
        i_en = 1'b1;
        step(100);
        i_en = 1'b0;
        step(200);
        chk("ramp_frames",    32'(c_done - s_done),   2);
        chk("ramp_fvld_cyc",  32'(c_fvld - s_fvld),   2 * FV);
        chk("ramp_lvld_cyc",  32'(c_lvld - s_lvld),   2 * VA * HA);
        chk("ramp_lvld_puls", 32'(c_lrise - s_lrise), 2 * VA);
        chk("ramp_idle",      32'(o_fvld),            0);

        // FIFO fully stocked
        q.delete();
        mq.delete();
        preload(24, 'h100, 1'b0);
        step(2);
        snap();
        i_pattern = 1'b0;
        i_en = 1'b1;
        step(40);
        i_en = 1'b0;
        step(150);
        chk("full_reads", 32'(c_rd - s_rd),     24);
        chk("full_dvld",  32'(c_dvld - s_dvld), 24);
        chk("full_uflow", 32'(o_underflow),     0);
        chk("full_left",  32'(q.size()),        0);

        // FIFO short by 14 words
        preload(10, 'h200, 1'b0);
        step(2);
        snap();
        i_en = 1'b1;
        step(40);
        i_en = 1'b0;
        step(150);
        chk("short_dvld",  32'(c_dvld - s_dvld), 10);
        chk("short_lvld",  32'(c_lvld - s_lvld), VA * HA);
        chk("short_reads", 32'(c_rd - s_rd),     10);
        chk("short_uflow", 32'(o_underflow),     1);

        // next frame clears underflow; pattern toggle mid-frame is ignored
        snap();
        i_pattern = 1'b1;
        i_en = 1'b1;
        step(3);
        chk("uflow_clr", 32'(o_underflow), 0);
        step(20);
        i_pattern = 1'b0;
        step(20);
        i_en = 1'b0;
        step(120);
        chk("tog_dvld",  32'(c_dvld - s_dvld), VA * HA);
        chk("tog_reads", 32'(c_rd - s_rd),     0);
        chk("tog_uflow", 32'(o_underflow),     0);

        // enable dropped during line 2
        snap();
        i_pattern = 1'b1;
        i_en = 1'b1;
        step(30);
        i_en = 1'b0;
        step(150);
        chk("drop_frames", 32'(c_done - s_done), 1);
        chk("drop_fvld",   32'(c_fvld - s_fvld), FV);

        // reset mid active line
        i_en = 1'b1;
        step(20);
        chk("pre_rst_lvld", 32'(o_lvld), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fvld", 32'(o_fvld),       0);
        chk("arst_lvld", 32'(o_lvld),       0);
        chk("arst_dvld", 32'(o_dvld),       0);
        chk("arst_data", 32'(o_data),       0);
        chk("arst_rd",   32'(o_fifo_rd_en), 0);
        step(2);
        snap();
        rst_n = 1'b1;
        step(20);
        chk("restart_lines", 32'(c_lrise - s_lrise), 1);
        i_en = 1'b0;
        step(150);

        // randomized frames
        for (int it = 0; it < 6; it++) begin
            int drop;
            q.delete();
            mq.delete();
            preload($urandom_range(0, 30), 0, 1'b1);
            step(2);
            i_pattern = 1'($urandom_range(0, 1));
            i_en = 1'b1;
            drop = $urandom_range(1, 160);
            for (int k = 0; k < drop; k++) begin
                step(1);
                if ($urandom_range(0, 15) == 0) i_pattern = ~i_pattern;
            end
            i_en = 1'b0;
            step(180);
            chk("rnd_idle", 32'(o_fvld), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
